// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the F1 reaction timer
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FOUL
  } rt_state_t;

  localparam int RT_W          = 14;
  localparam int RT_MAX_MS     = 9999;
  localparam int RT_LOCKOUT_MS = 5;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronise, edge-detect and lock out the reaction button
module btn_conditioner
  import f1_pkg::*;
#(
  parameter int LOCKOUT_MS = RT_LOCKOUT_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(LOCKOUT_MS + 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          locked;
  logic [CW-1:0] low_cnt;

  // The first clean rising edge fires immediately; everything after it is
  // masked until the button has been seen low for LOCKOUT_MS whole ticks.
  assign press = sync2 & ~prev & ~locked;

  // Two-flop synchroniser, edge history and lockout tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      locked  <= 1'b1;
      low_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (press) begin
        locked  <= 1'b1;
        low_cnt <= '0;
      end else if (locked) begin
        if (sync2) begin
          low_cnt <= '0;
        end else if (tick_ms) begin
          if (low_cnt == CW'(LOCKOUT_MS - 1)) begin
            locked  <= 1'b0;
            low_cnt <= '0;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - lights-out to button-press reaction timer with session best
module reaction_timer
  import f1_pkg::*;
#(
  parameter int W          = RT_W,
  parameter int MAX_MS     = RT_MAX_MS,
  parameter int LOCKOUT_MS = RT_LOCKOUT_MS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_ms,
  input  logic         lights_on,
  input  logic         lights_out,
  input  logic         react_raw,
  output logic [W-1:0] react_ms,
  output logic [W-1:0] best_ms,
  output logic         valid,
  output logic         false_start,
  output logic         new_best,
  output logic         busy
);

  localparam logic [W-1:0] MAX_V = W'(MAX_MS);

  rt_state_t    state;
  logic [W-1:0] counter;
  logic         press;

  btn_conditioner #(
    .LOCKOUT_MS(LOCKOUT_MS)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_ms(tick_ms),
    .raw    (react_raw),
    .press  (press)
  );

  // Round FSM; counter, results and best time all update with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      react_ms    <= '0;
      best_ms     <= MAX_V;
      valid       <= 1'b0;
      false_start <= 1'b0;
      new_best    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      new_best <= 1'b0;
      case (state)
        IDLE, DONE, FOUL: begin
          if (lights_on) begin
            state       <= ARMED;
            busy        <= 1'b1;
            valid       <= 1'b0;
            false_start <= 1'b0;
          end
        end
        ARMED: begin
          // A press wins over a coincident lights_out: that is a jump start.
          if (press) begin
            state       <= FOUL;
            busy        <= 1'b0;
            false_start <= 1'b1;
            react_ms    <= '0;
            valid       <= 1'b0;
          end else if (lights_out) begin
            state   <= TIMING;
            counter <= '0;
          end
        end
        TIMING: begin
          if (press) begin
            state    <= DONE;
            busy     <= 1'b0;
            react_ms <= counter;
            valid    <= 1'b1;
            if (counter < best_ms) begin
              best_ms  <= counter;
              new_best <= 1'b1;
            end
          end else if (counter == MAX_V) begin
            state    <= DONE;
            busy     <= 1'b0;
            react_ms <= MAX_V;
            valid    <= 1'b1;
          end else if (tick_ms) begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - self-checking bench for reaction_timer
module tb_reaction_timer;

  localparam int MAXMS = 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_ms;
  logic        lights_on;
  logic        lights_out;
  logic        react_raw;
  logic [13:0] react_ms;
  logic [13:0] best_ms;
  logic        valid;
  logic        false_start;
  logic        new_best;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int nb_count = 0;
  int exp_best = MAXMS;

  reaction_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .lights_on  (lights_on),
    .lights_out (lights_out),
    .react_raw  (react_raw),
    .react_ms   (react_ms),
    .best_ms    (best_ms),
    .valid      (valid),
    .false_start(false_start),
    .new_best   (new_best),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count clocks on which new_best is high, so a pulse wider than one clk shows up.
  always @(negedge clk) if (new_best === 1'b1) nb_count++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      cyc(1);
      tick_ms = 1'b0;
      cyc(1);
    end
  endtask

  task automatic release_btn();
    react_raw = 1'b0;
    cyc(3);
    ticks(6);
  endtask

  // One full round: lights sequence, then either a jump start or n ms of waiting.
  task automatic run_round(input int n, input bit foul);
    lights_on = 1'b1;
    cyc(1);
    ticks(3);
    if (foul) begin
      react_raw = 1'b1;
      cyc(2);
      lights_on = 1'b0;
      cyc(2);
    end else begin
      lights_on  = 1'b0;
      lights_out = 1'b1;
      cyc(1);
      lights_out = 1'b0;
      ticks(n);
      react_raw = 1'b1;
      cyc(4);
    end
    release_btn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++; if (react_ms !== 14'd0) $display("FAIL reset_react got=%0d exp=0", react_ms); else passes++;
    checks++; if (best_ms !== 14'(MAXMS)) $display("FAIL reset_best got=%0d exp=%0d", best_ms, MAXMS); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passes++;
    checks++; if (false_start !== 1'b0) $display("FAIL reset_fs got=%b exp=0", false_start); else passes++;
    checks++; if (new_best !== 1'b0) $display("FAIL reset_nb got=%b exp=0", new_best); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    rst_n = 1'b1;
    cyc(2);
    ticks(6);
  endtask

  task automatic test_first_round();
    int nb0;
    nb0 = nb_count;
    run_round(237, 1'b0);
    exp_best = 237;
    checks++; if (react_ms !== 14'd237) $display("FAIL r1_react got=%0d exp=237", react_ms); else passes++;
    checks++; if (valid !== 1'b1) $display("FAIL r1_valid got=%b exp=1", valid); else passes++;
    checks++; if (best_ms !== 14'd237) $display("FAIL r1_best got=%0d exp=237", best_ms); else passes++;
    checks++; if (nb_count - nb0 !== 1) $display("FAIL r1_new_best pulses got=%0d exp=1", nb_count - nb0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL r1_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_second_round();
    int nb0;
    nb0 = nb_count;
    run_round(300, 1'b0);
    checks++; if (react_ms !== 14'd300) $display("FAIL r2_react got=%0d exp=300", react_ms); else passes++;
    checks++; if (best_ms !== 14'd237) $display("FAIL r2_best got=%0d exp=237", best_ms); else passes++;
    checks++; if (nb_count - nb0 !== 0) $display("FAIL r2_new_best pulses got=%0d exp=0", nb_count - nb0); else passes++;
  endtask

  task automatic test_false_start();
    run_round(0, 1'b1);
    checks++; if (false_start !== 1'b1) $display("FAIL fs_flag got=%b exp=1", false_start); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL fs_valid got=%b exp=0", valid); else passes++;
    checks++; if (react_ms !== 14'd0) $display("FAIL fs_react got=%0d exp=0", react_ms); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL fs_busy got=%b exp=0", busy); else passes++;
    lights_on = 1'b1;
    cyc(1);
    checks++; if (false_start !== 1'b0) $display("FAIL fs_clear got=%b exp=0", false_start); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL fs_rearm_busy got=%b exp=1", busy); else passes++;
    lights_on  = 1'b0;
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    ticks(260);
    react_raw = 1'b1;
    cyc(4);
    release_btn();
    checks++; if (react_ms !== 14'd260) $display("FAIL fs_next_react got=%0d exp=260", react_ms); else passes++;
  endtask

  task automatic test_same_clk_foul();
    lights_on = 1'b1;
    cyc(1);
    ticks(2);
    react_raw = 1'b1;
    cyc(2);
    lights_on  = 1'b0;
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    cyc(2);
    checks++; if (false_start !== 1'b1) $display("FAIL same_clk_fs got=%b exp=1", false_start); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL same_clk_busy got=%b exp=0", busy); else passes++;
    release_btn();
  endtask

  task automatic test_timeout();
    int nb0;
    nb0 = nb_count;
    run_round(MAXMS, 1'b0);
    checks++; if (react_ms !== 14'(MAXMS)) $display("FAIL timeout_react got=%0d exp=%0d", react_ms, MAXMS); else passes++;
    checks++; if (valid !== 1'b1) $display("FAIL timeout_valid got=%b exp=1", valid); else passes++;
    checks++; if (best_ms !== 14'(exp_best)) $display("FAIL timeout_best got=%0d exp=%0d", best_ms, exp_best); else passes++;
    checks++; if (nb_count - nb0 !== 0) $display("FAIL timeout_nb got=%0d exp=0", nb_count - nb0); else passes++;
  endtask

  task automatic test_bounce();
    int nb0;
    nb0 = nb_count;
    lights_on = 1'b1;
    cyc(1);
    ticks(2);
    lights_on  = 1'b0;
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    ticks(150);
    react_raw = 1'b1;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      react_raw = ~react_raw;
      cyc(1);
    end
    cyc(3);
    if (150 < exp_best) exp_best = 150;
    checks++; if (react_ms !== 14'd150) $display("FAIL bounce_react got=%0d exp=150", react_ms); else passes++;
    checks++; if (nb_count - nb0 !== 1) $display("FAIL bounce_nb got=%0d exp=1", nb_count - nb0); else passes++;
    checks++; if (best_ms !== 14'(exp_best)) $display("FAIL bounce_best got=%0d exp=%0d", best_ms, exp_best); else passes++;
    lights_on = 1'b1;
    cyc(1);
    ticks(3);
    react_raw = 1'b1;
    cyc(4);
    checks++; if (false_start !== 1'b0) $display("FAIL lockout_fs got=%b exp=0", false_start); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL lockout_busy got=%b exp=1", busy); else passes++;
    release_btn();
    lights_on  = 1'b0;
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    ticks(400);
    react_raw = 1'b1;
    cyc(4);
    release_btn();
    checks++; if (react_ms !== 14'd400) $display("FAIL after_lockout_react got=%0d exp=400", react_ms); else passes++;
  endtask

  task automatic test_random();
    int n;
    int nb0;
    bit foul;
    int e_react;
    int e_nb;
    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(1, 400);
      foul = ($urandom_range(0, 3) == 0);
      nb0  = nb_count;
      run_round(n, foul);
      e_nb = 0;
      if (foul) begin
        e_react = 0;
      end else begin
        e_react = n;
        if (n < exp_best) begin
          exp_best = n;
          e_nb = 1;
        end
      end
      checks++; if (react_ms !== 14'(e_react)) $display("FAIL rnd%0d_react got=%0d exp=%0d", r, react_ms, e_react); else passes++;
      checks++; if (valid !== !foul) $display("FAIL rnd%0d_valid got=%b exp=%b", r, valid, !foul); else passes++;
      checks++; if (false_start !== foul) $display("FAIL rnd%0d_fs got=%b exp=%b", r, false_start, foul); else passes++;
      checks++; if (best_ms !== 14'(exp_best)) $display("FAIL rnd%0d_best got=%0d exp=%0d", r, best_ms, exp_best); else passes++;
      checks++; if (nb_count - nb0 !== e_nb) $display("FAIL rnd%0d_nb got=%0d exp=%0d", r, nb_count - nb0, e_nb); else passes++;
    end
  endtask

  task automatic test_mid_reset();
    lights_on = 1'b1;
    cyc(1);
    ticks(2);
    lights_on  = 1'b0;
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    ticks(50);
    checks++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy got=%b exp=1", busy); else passes++;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    checks++; if (react_ms !== 14'd0) $display("FAIL midrst_react got=%0d exp=0", react_ms); else passes++;
    checks++; if (best_ms !== 14'(MAXMS)) $display("FAIL midrst_best got=%0d exp=%0d", best_ms, MAXMS); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passes++;
    ticks(20);
    checks++; if (busy !== 1'b0) $display("FAIL midrst_idle got=%b exp=0", busy); else passes++;
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_ms    = 1'b0;
    lights_on  = 1'b0;
    lights_out = 1'b0;
    react_raw  = 1'b0;
    test_reset();
    test_first_round();
    test_second_round();
    test_false_start();
    test_same_clk_foul();
    test_timeout();
    test_bounce();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
